// File: rtl/alu_sequencer_if.sv
// Command, response and ALU-side bundle for alu_sequencer.
// The slave modport is the sequencer; the master modport drives commands and returns ALU results.
interface alu_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_load;
  logic [3:0]       cmd_op;
  logic [1:0]       cmd_rd;
  logic [1:0]       cmd_rs1;
  logic [1:0]       cmd_rs2;
  logic [WIDTH-1:0] cmd_imm;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_sel;
  logic [WIDTH-1:0] alu_out;
  logic             alu_carry;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_carry;
  logic             rsp_err;

  modport slave (
    input  cmd_valid, cmd_load, cmd_op,
    input  cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
    input  alu_out, alu_carry, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_sel,
    output rsp_valid, rsp_data, rsp_carry, rsp_err
  );

  modport master (
    output cmd_valid, cmd_load, cmd_op,
    output cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
    output alu_out, alu_carry, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_sel,
    input  rsp_valid, rsp_data, rsp_carry, rsp_err
  );
endinterface

// File: rtl/alu_sequencer.sv
// 4x16 register file sequencing loads and ALU ops through an external ALU.
// Optional ALU_SEQ_DIVZERO_CHECK_EN rejects op 0011 with a zero divisor.
module alu_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  alu_sequencer_if.slave io
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] r [4];
  logic [1:0]       rd_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [3:0]       sel_q;
  logic [WIDTH-1:0] data_q;
  logic             carry_q;
  logic             dz;
  logic             accept;

`ifdef ALU_SEQ_DIVZERO_CHECK_EN
  logic err_q;
  assign dz = ~io.cmd_load
            && (io.cmd_op == 4'b0011)
            && (r[io.cmd_rs2] == '0);
  assign io.rsp_err = err_q;
`else
  assign dz = 1'b0;
  assign io.rsp_err = 1'b0;
`endif

  assign accept       = (state == IDLE) && io.cmd_valid;
  assign io.cmd_ready = (state == IDLE) && !rst;
  assign io.rsp_valid = (state == RESP);
  assign io.alu_a     = a_q;
  assign io.alu_b     = b_q;
  assign io.alu_sel   = sel_q;
  assign io.rsp_data  = data_q;
  assign io.rsp_carry = carry_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (1'b1)
      (state == IDLE): begin
        if (io.cmd_valid)
          state_n = (io.cmd_load || dz) ? RESP : ISSUE;
      end
      (state == ISSUE): state_n = RESP;
      (state == RESP): begin
        if (io.rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r[i] <= '0;
      rd_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      data_q  <= '0;
      carry_q <= 1'b0;
`ifdef ALU_SEQ_DIVZERO_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else if (accept) begin
      if (io.cmd_load) begin
        r[io.cmd_rd] <= io.cmd_imm;
        data_q       <= io.cmd_imm;
        carry_q      <= 1'b0;
`ifdef ALU_SEQ_DIVZERO_CHECK_EN
        err_q        <= 1'b0;
`endif
      end else if (dz) begin
        data_q  <= '0;
        carry_q <= 1'b0;
`ifdef ALU_SEQ_DIVZERO_CHECK_EN
        err_q   <= 1'b1;
`endif
      end else begin
        a_q   <= r[io.cmd_rs1];
        b_q   <= r[io.cmd_rs2];
        sel_q <= io.cmd_op;
        rd_q  <= io.cmd_rd;
`ifdef ALU_SEQ_DIVZERO_CHECK_EN
        err_q <= 1'b0;
`endif
      end
    end else if (state == ISSUE) begin
      r[rd_q] <= io.alu_out;
      data_q  <= io.alu_out;
      carry_q <= io.alu_carry;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU model.
// Expected values are hand-computed per vector.
module tb_alu_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  alu_sequencer_if #(.WIDTH(16)) io ();

  alu_sequencer #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  // Model ALU: 0 add, 1 sub (borrow), 3 div, 4 inc, F equal.
  always_comb begin
    logic [16:0] t;
    t = '0;
    case (io.alu_sel)
      4'h0: t = {1'b0, io.alu_a} + {1'b0, io.alu_b};
      4'h1: t = {1'b0, io.alu_a} - {1'b0, io.alu_b};
      4'h3: t = (io.alu_b == 16'h0) ? 17'h0FFFF
              : {1'b0, io.alu_a / io.alu_b};
      4'h4: t = {1'b0, io.alu_a} + 17'h1;
      4'hF: t = {16'h0, io.alu_a == io.alu_b};
      default: t = '0;
    endcase
    io.alu_out   = t[15:0];
    io.alu_carry = t[16];
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic [3:0] op,
                       input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2, input logic [15:0] imm);
    io.cmd_load = ld;
    io.cmd_op   = op;
    io.cmd_rd   = rd;
    io.cmd_rs1  = rs1;
    io.cmd_rs2  = rs2;
    io.cmd_imm  = imm;
  endtask

  task automatic run(input logic ld, input logic [3:0] op,
                     input logic [1:0] rd, input logic [1:0] rs1,
                     input logic [1:0] rs2, input logic [15:0] imm,
                     output logic [15:0] d, output logic c,
                     output logic e, output int lat);
    int k;
    @(negedge clk);
    drive(ld, op, rd, rs1, rs2, imm);
    io.cmd_valid = 1'b1;
    k = 0;
    while (!io.cmd_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!io.cmd_ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    io.cmd_valid = 1'b0;
    lat = 1;
    while (!io.rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    if (!io.rsp_valid) chk("rsp_timeout", 0, 1);
    d = io.rsp_data;
    c = io.rsp_carry;
    e = io.rsp_err;
    io.rsp_ready = 1'b1;
    @(negedge clk);
    io.rsp_ready = 1'b0;
  endtask

  logic [15:0] d;
  logic        c;
  logic        e;
  int          lat;

  initial begin
    io.cmd_valid = 1'b0;
    io.rsp_ready = 1'b0;
    drive(1'b0, 4'h0, 2'd0, 2'd0, 2'd0, 16'h0);

    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", io.cmd_ready, 0);
    chk("rst_rsp_valid", io.rsp_valid, 0);
    chk("rst_alu_a", io.alu_a, 0);
    chk("rst_alu_b", io.alu_b, 0);
    chk("rst_alu_sel", io.alu_sel, 0);
    chk("rst_rsp_data", io.rsp_data, 0);
    chk("rst_rsp_carry", io.rsp_carry, 0);
    chk("rst_rsp_err", io.rsp_err, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", io.cmd_ready, 1);

    // Overflowing add, then read R2 back through the operand bus.
    run(1, 0, 0, 0, 0, 16'hFFFF, d, c, e, lat);
    chk("ld0_data", d, 16'hFFFF);
    chk("ld0_carry", c, 0);
    chk("ld0_lat", lat, 1);
    run(1, 0, 1, 0, 0, 16'h0001, d, c, e, lat);
    chk("ld1_data", d, 16'h0001);
    run(0, 4'h0, 2, 0, 1, 0, d, c, e, lat);
    chk("add_data", d, 16'h0000);
    chk("add_carry", c, 1);
    chk("add_lat", lat, 2);
    run(0, 4'hF, 3, 2, 2, 0, d, c, e, lat);
    chk("rb_r2_a", io.alu_a, 16'h0000);
    chk("rb_r2_sel", io.alu_sel, 4'hF);
    chk("rb_eq_data", d, 16'h0001);

    // Borrowing subtract.
    run(1, 0, 0, 0, 0, 16'h0000, d, c, e, lat);
    run(0, 4'h1, 3, 0, 1, 0, d, c, e, lat);
    chk("sub_data", d, 16'hFFFF);
    chk("sub_carry", c, 1);
    chk("sub_lat", lat, 2);

    // Backpressure with a second command waiting.
    @(negedge clk);
    drive(1, 0, 2, 0, 0, 16'h1234);
    io.cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drive(1, 0, 3, 0, 0, 16'hBEEF);
    for (int i = 0; i < 4; i++) begin
      chk("bp_valid", io.rsp_valid, 1);
      chk("bp_data", io.rsp_data, 16'h1234);
      chk("bp_ready", io.cmd_ready, 0);
      @(negedge clk);
    end
    io.rsp_ready = 1'b1;
    @(negedge clk);
    io.rsp_ready = 1'b0;
    chk("bp_idle_valid", io.rsp_valid, 0);
    chk("bp_idle_ready", io.cmd_ready, 1);
    @(negedge clk);
    io.cmd_valid = 1'b0;
    chk("bp_next_valid", io.rsp_valid, 1);
    chk("bp_next_data", io.rsp_data, 16'hBEEF);
    io.rsp_ready = 1'b1;
    @(negedge clk);
    io.rsp_ready = 1'b0;

    // Reset while the ALU command sits in ISSUE.
    drive(0, 4'h0, 0, 2, 3, 0);
    io.cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    io.cmd_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rsti_valid", io.rsp_valid, 0);
    chk("rsti_ready", io.cmd_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rsti_ready_after", io.cmd_ready, 1);
    chk("rsti_valid_after", io.rsp_valid, 0);
    run(0, 4'h0, 0, 2, 3, 0, d, c, e, lat);
    chk("rsti_r2", io.alu_a, 0);
    chk("rsti_r3", io.alu_b, 0);
    run(0, 4'h0, 1, 1, 0, 0, d, c, e, lat);
    chk("rsti_r1r0", d, 0);

    // Division by zero.
    run(1, 0, 1, 0, 0, 16'h0000, d, c, e, lat);
    run(1, 0, 0, 0, 0, 16'h0055, d, c, e, lat);
    run(0, 4'h3, 0, 0, 1, 0, d, c, e, lat);
`ifdef ALU_SEQ_DIVZERO_CHECK_EN
    chk("dz_err", e, 1);
    chk("dz_data", d, 16'h0000);
    chk("dz_carry", c, 0);
    chk("dz_lat", lat, 1);
    run(0, 4'h4, 2, 0, 0, 0, d, c, e, lat);
    chk("dz_r0_kept", d, 16'h0056);
`else
    chk("dz_err", e, 0);
    chk("dz_data", d, 16'hFFFF);
    chk("dz_lat", lat, 2);
    run(0, 4'h4, 2, 0, 0, 0, d, c, e, lat);
    chk("dz_r0_inc", d, 16'h0000);
    chk("dz_r0_carry", c, 1);
`endif
    chk("inc_err", e, 0);

    // Back-to-back dependent ops.
    run(0, 4'hF, 0, 0, 0, 0, d, c, e, lat);
    chk("b2b_eq", d, 16'h0001);
    run(0, 4'h4, 1, 0, 0, 0, d, c, e, lat);
    chk("b2b_inc_a", io.alu_a, 16'h0001);
    chk("b2b_inc", d, 16'h0002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
